wave_frame_writer: RTL



---
 rtl/wave_disp_pkg.sv | 10 +
 rtl/wave_y_scaler.sv | 40 ++++
 rtl/wave_frame_writer.sv | 116 +++++++++++
 3 files changed

// File: rtl/wave_disp_pkg.sv
// wave_disp_pkg: shared frame geometry, scaling constants and writer FSM encoding
package wave_disp_pkg;
  localparam int FRAME_LEN     = 300;
  localparam int IDX_W         = 9;
  localparam int Y_W           = 9;
  localparam int SCREEN_H      = 480;
  localparam int Y_SCALE_NUM   = 15;
  localparam int Y_SCALE_SHIFT = 3;
  typedef enum logic [1:0] {IDLE, CAPTURE, DRAIN, HOLD} state_t;
endpackage

// File: rtl/wave_y_scaler.sv
// wave_y_scaler: 2-stage sample-to-pixel-row pipeline (multiply/shift, then clamp/invert)
// Ports: clk/rst; in_valid/in_addr/in_data enter, out_valid/out_addr/out_data leave two cycles later.
module wave_y_scaler import wave_disp_pkg::*; #(
  parameter int H     = SCREEN_H,
  parameter int NUM   = Y_SCALE_NUM,
  parameter int SHIFT = Y_SCALE_SHIFT,
  parameter int AW    = IDX_W + 1,
  parameter int DW    = Y_W
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  input  logic [AW-1:0] in_addr,
  input  logic [7:0]    in_data,
  output logic          out_valid,
  output logic [AW-1:0] out_addr,
  output logic [DW-1:0] out_data
);
  logic          v1;
  logic [AW-1:0] a1;
  logic [11:0]   y1, prod, yc;
  assign prod = 12'(in_data) * 12'(NUM);
  assign yc   = (y1 > 12'(H - 1)) ? 12'(H - 1) : y1;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      v1        <= 1'b0;
      a1        <= '0;
      y1        <= '0;
      out_valid <= 1'b0;
      out_addr  <= '0;
      out_data  <= '0;
    end else begin
      v1        <= in_valid;
      a1        <= in_addr;
      y1        <= prod >> SHIFT;
      out_valid <= v1;
      out_addr  <= a1;
      out_data  <= DW'(12'(H - 1) - yc);
    end
endmodule

// File: rtl/wave_frame_writer.sv
// wave_frame_writer: writes one scaled waveform frame per bank of a ping-pong display BRAM
// Ports: rd_clk/rst (async, active-high); s_data/s_valid/s_ready from the capture FIFO;
//   ram_ready = free bank; disp_vsync/disp_bank display handshake; ram_we/ram_addr/ram_wdata
//   BRAM write port; frame_done pulses with the last write.
// Option WAVE_MEAS_EN: adds meas_min/meas_max/meas_valid raw sample extremes per frame.
module wave_frame_writer #(
  parameter int FRAME_LEN     = wave_disp_pkg::FRAME_LEN,
  parameter int IDX_W         = wave_disp_pkg::IDX_W,
  parameter int Y_W           = wave_disp_pkg::Y_W,
  parameter int SCREEN_H      = wave_disp_pkg::SCREEN_H,
  parameter int Y_SCALE_NUM   = wave_disp_pkg::Y_SCALE_NUM,
  parameter int Y_SCALE_SHIFT = wave_disp_pkg::Y_SCALE_SHIFT
) (
  input  logic           rd_clk,
  input  logic           rst,
  input  logic [7:0]     s_data,
  input  logic           s_valid,
  output logic           s_ready,
  output logic           ram_ready,
  input  logic           disp_vsync,
  output logic           disp_bank,
  output logic           ram_we,
  output logic [IDX_W:0] ram_addr,
  output logic [Y_W-1:0] ram_wdata,
  output logic           frame_done
`ifdef WAVE_MEAS_EN
  ,
  output logic [7:0]     meas_min,
  output logic [7:0]     meas_max,
  output logic           meas_valid
`endif
);
  import wave_disp_pkg::*;
  state_t           state, state_n;
  logic             dcnt, wr_bank, pending, accept, swap;
  logic [IDX_W-1:0] idx;
  assign accept    = s_valid & s_ready;
  assign ram_ready = ~pending;
  always_ff @(posedge rd_clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_n;
  always_comb begin
    state_n    = state;
    s_ready    = 1'b0;
    frame_done = 1'b0;
    swap       = 1'b0;
    case (state)
      IDLE:    state_n = CAPTURE;
      CAPTURE: begin
        s_ready = 1'b1;
        if (s_valid && idx == IDX_W'(FRAME_LEN - 1)) state_n = DRAIN;
      end
      DRAIN:   if (dcnt) begin
        frame_done = 1'b1;
        state_n    = HOLD;
      end
      HOLD:    if (disp_vsync && pending) begin
        swap    = 1'b1;
        state_n = CAPTURE;
      end
      default: state_n = IDLE;
    endcase
  end
  // dcnt counts the two pipeline-flush cycles spent in DRAIN
  always_ff @(posedge rd_clk or posedge rst)
    if (rst) begin
      dcnt      <= 1'b0;
      wr_bank   <= 1'b1;
      disp_bank <= 1'b0;
      pending   <= 1'b0;
      idx       <= '0;
    end else begin
      dcnt <= (state == DRAIN) && !dcnt;
      if (accept) idx <= idx + 1'b1;
      if (frame_done) pending <= 1'b1;
      if (swap) begin
        disp_bank <= wr_bank;
        wr_bank   <= ~wr_bank;
        pending   <= 1'b0;
        idx       <= '0;
      end
    end
  wave_y_scaler #(
    .H(SCREEN_H), .NUM(Y_SCALE_NUM), .SHIFT(Y_SCALE_SHIFT), .AW(IDX_W + 1), .DW(Y_W)
  ) u_scaler (
    .clk(rd_clk),
    .rst(rst),
    .in_valid(accept),
    .in_addr({wr_bank, idx}),
    .in_data(s_data),
    .out_valid(ram_we),
    .out_addr(ram_addr),
    .out_data(ram_wdata)
  );
`ifdef WAVE_MEAS_EN
  logic [7:0] cur_min, cur_max;
  assign meas_valid = frame_done;
  // running extremes restart on index 0; published on the first DRAIN cycle so they land with frame_done
  always_ff @(posedge rd_clk or posedge rst)
    if (rst) begin
      cur_min  <= '0;
      cur_max  <= '0;
      meas_min <= '0;
      meas_max <= '0;
    end else begin
      if (accept) begin
        cur_min <= (idx == '0 || s_data < cur_min) ? s_data : cur_min;
        cur_max <= (idx == '0 || s_data > cur_max) ? s_data : cur_max;
      end
      if (state == DRAIN && !dcnt) begin
        meas_min <= cur_min;
        meas_max <= cur_max;
      end
    end
`endif
endmodule
